// File: rtl/branch_pc_sequencer.sv
// branch_pc_sequencer: multi-cycle PC controller for the branch-select datapath.
// Fetches an instruction over a req/ack handshake, hands the IR to the decoders,
// samples the returned branch codes, waits for the ALU zero flag when the op
// needs it, then commits the next PC.
// Optional feature macro: PC_MISALIGN_TRAP_EN (trap on a misaligned taken target
// instead of silently aligning it).
module branch_pc_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic [1:0]  branch_op,
    input  logic [2:0]  branch_base_src,
    input  logic [2:0]  branch_offset_src,
    input  logic [31:0] rs1_data,
    input  logic        alu_zero,
    input  logic        alu_valid,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        retire,
`ifdef PC_MISALIGN_TRAP_EN
    output logic        fault,
    output logic        trap,
    output logic [31:0] trap_pc
`else
    output logic        fault
`endif
);

    localparam logic [7:0] TO_LIM = 8'(FETCH_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_COMMIT = 3'd4,
        S_FAULT  = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q, ir_q, next_pc_q;
    logic [1:0]  op_q;
    logic [2:0]  base_q, off_q;
    logic [7:0]  cnt_q;
    logic        fetch_req_q, instr_valid_q, retire_q, fault_q;
`ifdef PC_MISALIGN_TRAP_EN
    logic        trap_q;
    logic [31:0] trap_pc_q;
`endif

    logic [31:0] imm_i, imm_b, imm_j;
    logic [31:0] base_val, off_val, target, link_d, next_pc_d;
    logic [7:0]  cnt_inc;
    logic        taken, exec_done;

    assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign link_d  = pc_q + 32'd4;
    assign cnt_inc = cnt_q + 8'd1;

    // Base/offset selection, target formation and branch resolution
    always_comb begin
        base_val = 32'd0;
        case (base_q)
            3'b001:  base_val = link_d;
            3'b010:  base_val = pc_q;
            3'b011:  base_val = rs1_data;
            default: base_val = 32'd0;
        endcase
        off_val = 32'd0;
        case (off_q)
            3'b100:  off_val = imm_i;
            3'b101:  off_val = imm_j;
            3'b110:  off_val = imm_b;
            default: off_val = 32'd0;
        endcase
        target = base_val + off_val;
        // register-indirect jumps drop bit0 like jalr
        if (base_q == 3'b011) target[0] = 1'b0;
        // unknown or 00 ops fall through to the default: never taken
        taken     = 1'b0;
        exec_done = 1'b1;
        case (op_q)
            2'b01: begin taken = !alu_zero; exec_done = alu_valid; end
            2'b10: begin taken = alu_zero;  exec_done = alu_valid; end
            2'b11: taken = 1'b1;
            default: begin taken = 1'b0; exec_done = 1'b1; end
        endcase
`ifdef PC_MISALIGN_TRAP_EN
        next_pc_d = taken ? target : link_d;
`else
        next_pc_d = taken ? {target[31:2], 2'b00} : link_d;
`endif
    end

    // Sequencer FSM with registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            ir_q          <= 32'd0;
            next_pc_q     <= 32'd0;
            op_q          <= 2'd0;
            base_q        <= 3'd0;
            off_q         <= 3'd0;
            cnt_q         <= 8'd0;
            fetch_req_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            retire_q      <= 1'b0;
            fault_q       <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q        <= 1'b0;
            trap_pc_q     <= 32'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q     <= S_FETCH;
                        fetch_req_q <= 1'b1;
                        cnt_q       <= 8'd0;
                    end
                end
                S_FETCH: begin
                    // an ack on the limit cycle still completes the fetch
                    if (fetch_ack) begin
                        ir_q          <= fetch_data;
                        cnt_q         <= 8'd0;
                        fetch_req_q   <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_DECODE;
                    end else if (cnt_inc == TO_LIM) begin
                        cnt_q       <= cnt_inc;
                        fetch_req_q <= 1'b0;
                        fault_q     <= 1'b1;
                        state_q     <= S_FAULT;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                S_DECODE: begin
                    instr_valid_q <= 1'b0;
                    op_q          <= branch_op;
                    base_q        <= branch_base_src;
                    off_q         <= branch_offset_src;
                    state_q       <= S_EXEC;
                end
                S_EXEC: begin
                    if (exec_done) begin
`ifdef PC_MISALIGN_TRAP_EN
                        if (taken && (target[1:0] != 2'b00)) begin
                            trap_q    <= 1'b1;
                            trap_pc_q <= pc_q;
                            state_q   <= S_TRAP;
                        end else begin
                            next_pc_q <= next_pc_d;
                            retire_q  <= 1'b1;
                            state_q   <= S_COMMIT;
                        end
`else
                        next_pc_q <= next_pc_d;
                        retire_q  <= 1'b1;
                        state_q   <= S_COMMIT;
`endif
                    end
                end
                S_COMMIT: begin
                    pc_q     <= next_pc_q;
                    retire_q <= 1'b0;
                    if (run) begin
                        state_q     <= S_FETCH;
                        fetch_req_q <= 1'b1;
                        cnt_q       <= 8'd0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                // FAULT and TRAP are terminal until reset
                default: begin
                    fetch_req_q   <= 1'b0;
                    instr_valid_q <= 1'b0;
                    retire_q      <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_req   = fetch_req_q;
    assign fetch_addr  = pc_q;
    assign instr_out   = ir_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign link_addr   = link_d;
    assign retire      = retire_q;
    assign fault       = fault_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign trap        = trap_q;
    assign trap_pc     = trap_pc_q;
`endif

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Bench for branch_pc_sequencer: directed instruction sequence, expected
// commit records queued by the driver and checked by a retire monitor.
module tb_branch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack = 1'b0;
    logic [31:0] fetch_data = 32'd0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [1:0]  branch_op = 2'd0;
    logic [2:0]  branch_base_src = 3'd0;
    logic [2:0]  branch_offset_src = 3'd0;
    logic [31:0] rs1_data = 32'd0;
    logic        alu_zero = 1'b0;
    logic        alu_valid = 1'b0;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        retire;
    logic        fault;
`ifdef PC_MISALIGN_TRAP_EN
    logic        trap;
    logic [31:0] trap_pc;
`endif

    branch_pc_sequencer #(.RESET_PC(32'h0), .FETCH_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .instr_out(instr_out), .instr_valid(instr_valid),
        .branch_op(branch_op), .branch_base_src(branch_base_src),
        .branch_offset_src(branch_offset_src), .rs1_data(rs1_data),
        .alu_zero(alu_zero), .alu_valid(alu_valid),
        .pc(pc), .link_addr(link_addr), .retire(retire),
`ifdef PC_MISALIGN_TRAP_EN
        .fault(fault), .trap(trap), .trap_pc(trap_pc)
`else
        .fault(fault)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc_old;
        logic [31:0] link;
        logic [31:0] pc_new;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int i;
        for (i = 0; i < 40 && !fetch_req; i++) step();
        if (!fetch_req) check("fetch_req_timeout", {31'd0, fetch_req}, 32'd1);
    endtask

    // Issue one instruction; queue its commit record unless a trap is expected
    task automatic issue(input logic [31:0] instr, input logic [1:0] op,
                         input logic [2:0] base, input logic [2:0] off,
                         input logic [31:0] rs1, input int ack_dly, input int alu_dly,
                         input logic zero, input logic [31:0] pc_old,
                         input logic [31:0] pc_new, input bit expect_retire);
        exp_t e;
        int   i;
        wait_req();
        if (expect_retire) begin
            e.pc_old = pc_old;
            e.link   = pc_old + 32'd4;
            e.pc_new = pc_new;
            e.lat    = 4 + alu_dly;
            exp_q.push_back(e);
        end
        branch_op = op; branch_base_src = base; branch_offset_src = off;
        rs1_data = rs1; alu_valid = 1'b0;
        repeat (ack_dly) step();
        fetch_ack = 1'b1; fetch_data = instr;
        step();
        fetch_ack = 1'b0;
        step();
        repeat (alu_dly) step();
        alu_valid = 1'b1; alu_zero = zero;
        if (expect_retire) begin
            for (i = 0; i < 20 && !retire; i++) step();
            if (!retire) check("retire_timeout", {31'd0, retire}, 32'd1);
        end else begin
            step();
        end
        alu_valid = 1'b0;
    endtask

    // Retire monitor: compares every commit against the queued record
    initial begin
        int   cyc = 0;
        int   stamp = 0;
        int   ivcnt = 0;
        bit   chk_next = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                ivcnt = 0; chk_next = 0;
            end else begin
                if (chk_next) begin
                    check("pc_after_commit", pc, e.pc_new);
                    chk_next = 0;
                end
                if (fetch_req && fetch_ack) stamp = cyc;
                if (instr_valid) ivcnt++;
                if (retire) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_retire", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pc_at_retire", pc, e.pc_old);
                        check("link_at_retire", link_addr, e.link);
                        check("latency", 32'(cyc - stamp + 1), 32'(e.lat));
                        check("instr_valid_pulses", 32'(ivcnt), 32'd1);
                        chk_next = 1;
                    end
                    ivcnt = 0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got expired expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        #12;
        check("rst_pc", pc, 32'h0);
        check("rst_ir", instr_out, 32'h0);
        check("rst_strobes", {28'd0, fetch_req, instr_valid, retire, fault}, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("idle_no_req", {31'd0, fetch_req}, 32'd0);
        run = 1'b1;

        // addi, not taken
        issue(32'h0000_0013, 2'b00, 3'b000, 3'b000, 32'h0, 1, 0, 1'b0, 32'h0, 32'h4, 1);
        // absolute jump to 0x100 (zero + I-imm)
        issue(32'h1000_0000, 2'b11, 3'b000, 3'b100, 32'h0, 0, 0, 1'b0, 32'h4, 32'h100, 1);
        // beq -8, ALU late by 3, zero -> taken
        issue(32'hFE00_0C80, 2'b10, 3'b010, 3'b110, 32'h0, 0, 3, 1'b1, 32'h100, 32'hF8, 1);
        issue(32'h1000_0000, 2'b11, 3'b000, 3'b100, 32'h0, 0, 0, 1'b0, 32'hF8, 32'h100, 1);
        // beq -8, non-zero -> fall through
        issue(32'hFE00_0C80, 2'b10, 3'b010, 3'b110, 32'h0, 0, 3, 1'b0, 32'h100, 32'h104, 1);
        // bne -8, non-zero -> taken
        issue(32'hFE00_0C80, 2'b01, 3'b010, 3'b110, 32'h0, 0, 1, 1'b0, 32'h104, 32'hFC, 1);
        issue(32'h1000_0000, 2'b11, 3'b000, 3'b100, 32'h0, 0, 0, 1'b0, 32'hFC, 32'h100, 1);
        // jalr rs1=0x2001 + 4, bit0 cleared
        issue(32'h0040_0000, 2'b11, 3'b011, 3'b100, 32'h2001, 0, 0, 1'b0, 32'h100, 32'h2004, 1);
        // jump to -16; ack on the timeout limit cycle still wins
        issue(32'hFF00_0000, 2'b11, 3'b000, 3'b100, 32'h0, 15, 0, 1'b0, 32'h2004, 32'hFFFF_FFF0, 1);
        check("no_fault_ack_at_limit", {31'd0, fault}, 32'd0);
        // jal +0x20 wraps
        issue(32'h0200_0000, 2'b11, 3'b010, 3'b101, 32'h0, 0, 0, 1'b0, 32'hFFFF_FFF0, 32'h10, 1);
        // jump to -4, then fall through wraps pc and link to 0
        issue(32'hFFC0_0000, 2'b11, 3'b000, 3'b100, 32'h0, 0, 0, 1'b0, 32'h10, 32'hFFFF_FFFC, 1);
        issue(32'h0000_0013, 2'b00, 3'b000, 3'b000, 32'h0, 0, 0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1);
        // unlisted base code selects 0; unlisted offset code selects 0
        issue(32'h0200_0000, 2'b11, 3'b111, 3'b100, 32'h0, 0, 0, 1'b0, 32'h0, 32'h20, 1);
        issue(32'h0200_0000, 2'b11, 3'b010, 3'b011, 32'h0, 0, 0, 1'b0, 32'h20, 32'h20, 1);
        // misaligned jalr target 0x2002
`ifdef PC_MISALIGN_TRAP_EN
        issue(32'h0010_0000, 2'b11, 3'b011, 3'b100, 32'h2001, 0, 0, 1'b0, 32'h20, 32'h20, 0);
        check("trap_set", {31'd0, trap}, 32'd1);
        check("trap_pc", trap_pc, 32'h20);
        check("trap_pc_held", pc, 32'h20);
        step();
        check("trap_no_retire", {30'd0, retire, fetch_req}, 32'd0);
`else
        issue(32'h0010_0000, 2'b11, 3'b011, 3'b100, 32'h2001, 0, 0, 1'b0, 32'h20, 32'h2000, 1);
        step();
        wait_req();
        repeat (3) step();
        check("pc_mid_fetch", pc, 32'h2000);
`endif
        // async reset mid-transaction
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_strobes", {30'd0, fetch_req, fault}, 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
        check("async_rst_trap", {31'd0, trap}, 32'd0);
`endif
        run = 1'b0;
        step();
        rst_n = 1'b1;
        // late ack in IDLE is ignored
        fetch_ack = 1'b1; fetch_data = 32'hDEAD_BEEF;
        step();
        step();
        fetch_ack = 1'b0;
        check("idle_ack_ignored", {31'd0, instr_valid}, 32'd0);
        check("idle_ir_unchanged", instr_out, 32'h0);

        // fetch timeout
        run = 1'b1;
        wait_req();
        repeat (15) step();
        check("timeout_still_fetching", {30'd0, fetch_req, fault}, 32'h2);
        step();
        check("timeout_fault", {30'd0, fetch_req, fault}, 32'h1);
        repeat (3) step();
        check("fault_sticky", {30'd0, fetch_req, fault}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("fault_cleared_by_reset", {31'd0, fault}, 32'd0);
        step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_pc_sequencer.md
Name: branch_pc_sequencer

Overview:
- Multi-cycle program-counter controller that drives the branch-select datapath.
- Fetches an instruction through a req/ack handshake, presents it to the decode/translator stage, and samples the returned branch_op, branch_base_src and branch_offset_src codes.
- Waits for the ALU zero flag where needed, then commits the next PC.
- Sits between instruction memory, the decode translators and the ALU.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- FETCH_TIMEOUT, 16: maximum FETCH cycles without fetch_ack before a fault; range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; while high the sequencer keeps executing.
- fetch_req  out  1  instruction fetch request.
- fetch_addr  out  32  fetch address; always equals pc.
- fetch_ack  in  1  fetch completion; fetch_data valid this cycle.
- fetch_data  in  32  instruction word.
- instr_out  out  32  latched instruction register (IR) to the decoders.
- instr_valid  out  1  one-cycle pulse, IR newly valid.
- branch_op  in  2  00 never, 01 taken if ALU non-zero, 10 taken if ALU zero, 11 always.
- branch_base_src  in  3  000 zero, 001 pc+4, 010 pc, 011 rs1.
- branch_offset_src  in  3  000 zero, 100 I-imm, 101 J-imm, 110 B-imm.
- rs1_data  in  32  register operand for base src 011.
- alu_zero  in  1  ALU result == 0.
- alu_valid  in  1  alu_zero valid this cycle.
- pc  out  32  current PC.
- link_addr  out  32  pc+4, return address for rd.
- retire  out  1  one-cycle pulse when the PC commits.
- fault  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, IR=0.
  - fetch_req, instr_valid, retire and fault are 0; latched codes are 0; timeout counter is 0.
  - Applies immediately mid-transaction; an in-flight fetch is abandoned and a late ack is ignored in IDLE.
- States: IDLE, FETCH, DECODE, EXEC, COMMIT, FAULT.
- IDLE:
  - All strobes are 0.
  - Goes to FETCH on the next edge when run=1.
- FETCH:
  - fetch_req=1 and fetch_addr=pc for the whole state.
  - On fetch_ack=1: IR<=fetch_data, counter cleared, go to DECODE.
  - Otherwise the counter increments; when it reaches FETCH_TIMEOUT without an ack, go to FAULT.
  - An ack arriving in the same cycle the counter reaches its limit wins.
- DECODE:
  - Exactly one cycle with instr_valid=1.
  - branch_op and both src codes are sampled at the end of this cycle.
  - Go to EXEC.
- EXEC:
  - Ops 01 and 10 hold in EXEC while alu_valid=0.
  - Ops 00 and 11 ignore alu_valid and leave after one cycle.
  - On leaving, next_pc is latched from rs1_data and alu_zero sampled that cycle, and the state goes to COMMIT.
- COMMIT:
  - pc<=next_pc, retire=1 for one cycle.
  - Go to FETCH if run=1, else IDLE.
  - run is only sampled in IDLE and COMMIT.
- FAULT:
  - fault=1 and all strobes are 0.
  - Exits only through reset.
- Immediates:
  - I-imm: sign-extended instr[31:20].
  - B-imm: sign-extended {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
  - J-imm: sign-extended {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}.
- Target and next PC:
  - target = base + offset, mod 2^32, so wrap-around is silent.
  - When base src is 011, target bit0 is cleared.
  - taken: op 00 → 0; op 01 → !alu_zero; op 10 → alu_zero; op 11 → 1.
  - Any X/unknown op is treated as 00.
  - Unlisted src codes select 0.
  - next_pc = taken ? target : pc+4.
- link_addr = pc+4 combinationally; pc=32'hFFFF_FFFC gives link_addr 0.
- Minimum latency per instruction: ack cycle + DECODE + EXEC + COMMIT = 4 cycles.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- When defined:
  - A taken target with target[1:0]!=2'b00 is not committed; pc is held.
  - The sequencer enters TRAP.
  - Added ports: trap (out 1, sticky) and trap_pc (out 32, pc of the faulting instruction).
  - TRAP exits only through reset; reset values are trap=0 and trap_pc=0.
- When not defined:
  - target[1:0] is forced to 2'b00 on commit.
  - No trap ports exist.

Test Plan:
- Reset then run=1; fetch_ack 1 cycle after req with 0x00000013 (addi); op=00 → retire after 4 cycles, pc=0x4, instr_valid pulsed once.
- pc=0x100, beq (B-imm=-8), op=10; alu_valid delayed 3 cycles, then alu_zero=1 → EXEC holds 3 extra cycles, pc=0xF8; repeat with alu_zero=0 → pc=0x104.
- jalr with rs1_data=0x2001, I-imm=+4, op=11, base 011, offset 100 → pc=0x2004 (bit0 cleared), link_addr=0x104 before commit.
- jal at pc=0xFFFF_FFF0 with J-imm=+0x20 → pc=0x0000_0010 (wrap).
- fetch_ack withheld for FETCH_TIMEOUT=16 cycles → fault=1 and fetch_req=0 on the next cycle; rst_n low mid-FETCH → pc=RESET_PC, fault=0 immediately.
- With PC_MISALIGN_TRAP_EN: jalr target 0x2002 → trap=1, trap_pc=instr pc, pc unchanged; without the macro, the same stimulus gives pc=0x2000.
